// File: rtl/pwm_pkg.sv
// Shared definitions for the N-phase commutating PWM generator: controller
// state encodings, width helpers and the power-on duty value.
package pwm_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam int PWM_RESET_DUTY = 31;

  // Slot counter and duty share a width wide enough to hold SLOT_LEN itself.
  function automatic int pwm_slot_w(input int slot_len);
    return $clog2(slot_len + 1);
  endfunction

  function automatic int pwm_ph_w(input int num_phases);
    return (num_phases > 1) ? $clog2(num_phases) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every presc+1 clk cycles; held at zero while clear.
module pwm_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = !clear && (cnt == presc);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_commutator.sv
// N-phase commutating PWM generator with shadowed duty/prescaler updates.
// Define PWM_DIR_EN to add the dir input selecting reverse rotation order.
module pwm_commutator
  import pwm_pkg::*;
#(
  parameter int NUM_PHASES   = 3,
  parameter int SLOT_LEN     = 33,
  parameter int DEAD_TIME    = 2,
  parameter int PRESC_W      = 8,
  parameter int DEFAULT_DUTY = PWM_RESET_DUTY,
  parameter int SLOT_W       = pwm_slot_w(SLOT_LEN),
  parameter int PH_W         = pwm_ph_w(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
`ifdef PWM_DIR_EN
  input  logic                  dir,
`endif
  input  logic [SLOT_W-1:0]     duty_in,
  input  logic [PRESC_W-1:0]    presc_in,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic [NUM_PHASES-1:0] pwm,
  output logic [PH_W-1:0]       phase_idx,
  output logic                  busy,
  output logic                  rot_pulse
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] DUTY_MAX  = SLOT_W'(SLOT_LEN - DEAD_TIME);
  localparam logic [SLOT_W:0]   DEAD      = (SLOT_W+1)'(DEAD_TIME);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(NUM_PHASES - 1);

  logic [1:0]            state;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [PH_W-1:0]       phase_cnt;
  logic [SLOT_W-1:0]     duty_act, duty_sh;
  logic [PRESC_W-1:0]    presc_act, presc_sh;
  logic                  pending;

  logic                  tick, slot_end, rot_end, keep_running;
  logic                  accept, apply;
  logic [PH_W-1:0]       phase_next, rot_last;
  logic [SLOT_W-1:0]     duty_eff;
  logic [SLOT_W:0]       on_end;
  logic [NUM_PHASES-1:0] pwm_next;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE),
    .presc (presc_act),
    .tick  (tick)
  );

`ifdef PWM_DIR_EN
  logic rev;
  assign rot_last   = rev ? PH_W'(1) : PH_LAST;
  assign phase_next = rev ? ((phase_cnt == '0) ? PH_LAST : phase_cnt - 1'b1)
                          : ((phase_cnt == PH_LAST) ? '0 : phase_cnt + 1'b1);
`else
  assign rot_last   = PH_LAST;
  assign phase_next = (phase_cnt == PH_LAST) ? '0 : phase_cnt + 1'b1;
`endif

  // A wrap only counts as a rotation boundary when the sequence carries on;
  // a stop that ends on the last slot just falls back to IDLE.
  assign keep_running = (state == ST_RUN) || (state == ST_STOPPING && en);
  assign slot_end     = tick && (slot_cnt == SLOT_LAST);
  assign rot_end      = slot_end && (phase_cnt == rot_last) && keep_running;

  assign accept    = upd_valid && !pending;
  assign apply     = pending && (state == ST_IDLE || rot_end);
  assign upd_ready = !pending;
  assign busy      = (state != ST_IDLE);

  assign duty_eff = (duty_act > DUTY_MAX) ? DUTY_MAX : duty_act;
  assign on_end   = DEAD + {1'b0, duty_eff};

  // NOTE: assign a default before any conditional update so no latch is inferred.
  always_comb begin
    pwm_next = '0;
    if (busy && ({1'b0, slot_cnt} >= DEAD) && ({1'b0, slot_cnt} < on_end))
      pwm_next[phase_cnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot_cnt  <= '0;
      phase_cnt <= '0;
      duty_act  <= SLOT_W'(DEFAULT_DUTY);
      presc_act <= '0;
      duty_sh   <= '0;
      presc_sh  <= '0;
      pending   <= 1'b0;
      pwm       <= '0;
      phase_idx <= '0;
      rot_pulse <= 1'b0;
    end else begin
      pwm       <= pwm_next;
      phase_idx <= phase_cnt;
      rot_pulse <= rot_end;

      // accept needs an empty shadow and apply a full one, so they never collide.
      if (accept) begin
        duty_sh  <= duty_in;
        presc_sh <= presc_in;
        pending  <= 1'b1;
      end else if (apply) begin
        duty_act  <= duty_sh;
        presc_act <= presc_sh;
        pending   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          slot_cnt  <= '0;
          phase_cnt <= '0;
          if (en) state <= ST_RUN;
        end
        ST_RUN, ST_STOPPING: begin
          if (state == ST_STOPPING && !en && slot_end) begin
            state     <= ST_IDLE;
            slot_cnt  <= '0;
            phase_cnt <= '0;
          end else begin
            state <= en ? ST_RUN : ST_STOPPING;
            if (slot_end) begin
              slot_cnt  <= '0;
              phase_cnt <= phase_next;
            end else if (tick) begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PWM_DIR_EN
  always_ff @(posedge clk) begin
    if (rst)                            rev <= 1'b0;
    else if ((state == ST_IDLE && en) || rot_end) rev <= dir;
  end
`endif

endmodule

// File: tb/tb_pwm_commutator.sv
// Directed self-checking bench for pwm_commutator (default 3-phase build;
// the reverse-order section is compiled only when PWM_DIR_EN is defined).
module tb_pwm_commutator;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] duty_in;
  logic [7:0] presc_in;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] pwm;
  logic [1:0] phase_idx;
  logic       busy;
  logic       rot_pulse;
`ifdef PWM_DIR_EN
  logic       dir;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_commutator #(
    .NUM_PHASES(3), .SLOT_LEN(33), .DEAD_TIME(2), .PRESC_W(8), .DEFAULT_DUTY(31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef PWM_DIR_EN
    .dir       (dir),
`endif
    .duty_in   (duty_in),
    .presc_in  (presc_in),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .pwm       (pwm),
    .phase_idx (phase_idx),
    .busy      (busy),
    .rot_pulse (rot_pulse)
  );

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; upd_valid = 1'b0; duty_in = '0; presc_in = '0;
`ifdef PWM_DIR_EN
    dir = 1'b0;
`endif
    tick_n(2);
    check("rst_pwm", pwm, 0);
    check("rst_phase", phase_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_rot", rot_pulse, 0);
    check("rst_ready", upd_ready, 1);
    rst = 1'b0;
    tick_n(1);
    check("idle_busy", busy, 0);

    // Defaults: presc 0, duty 31, 33-tick slots.
    en = 1'b1;
    tick_n(1);   check("run_busy", busy, 1);       check("run_pwm0", pwm, 0);
    tick_n(2);   check("dead_pwm", pwm, 0);
    tick_n(1);   check("p0_rise", pwm, 3'b001);    check("p0_idx", phase_idx, 0);
    tick_n(30);  check("p0_last", pwm, 3'b001);
    tick_n(1);   check("p1_dead", pwm, 3'b000);    check("p1_idx", phase_idx, 1);
    tick_n(2);   check("p1_rise", pwm, 3'b010);
    tick_n(33);  check("p2_rise", pwm, 3'b100);    check("p2_idx", phase_idx, 2);
    tick_n(29);  check("rot_early", rot_pulse, 0);
    tick_n(1);   check("rot_pulse", rot_pulse, 1); check("p2_last", pwm, 3'b100);
    tick_n(1);   check("rot_once", rot_pulse, 0);  check("wrap_pwm", pwm, 0);
    check("wrap_idx", phase_idx, 0);

    // Shadow update while running: presc 3, duty 10.
    duty_in = 6'd10; presc_in = 8'd3; upd_valid = 1'b1;
    tick_n(1);   check("upd_taken", upd_ready, 0);
    upd_valid = 1'b0;
    tick_n(96);  check("upd_held", upd_ready, 0);
    tick_n(1);   check("upd_rot", rot_pulse, 1);   check("upd_free", upd_ready, 1);
    tick_n(8);   check("slow_dead", pwm, 0);
    tick_n(1);   check("slow_rise", pwm, 3'b001);
    tick_n(39);  check("slow_last", pwm, 3'b001);
    tick_n(1);   check("slow_fall", pwm, 0);
    tick_n(91);  check("slow_p1_dead", pwm, 0);
    tick_n(1);   check("slow_p1_rise", pwm, 3'b010); check("slow_p1_idx", phase_idx, 1);

    // Reset mid-pulse with an update pending.
    duty_in = 6'd7; presc_in = 8'd0; upd_valid = 1'b1;
    tick_n(1);   check("mid_pulse", pwm, 3'b010);  check("pend_ready", upd_ready, 0);
    upd_valid = 1'b0; rst = 1'b1; en = 1'b0;
    tick_n(1);
    check("mrst_pwm", pwm, 0);
    check("mrst_busy", busy, 0);
    check("mrst_phase", phase_idx, 0);
    check("mrst_ready", upd_ready, 1);
    rst = 1'b0; en = 1'b1;
    tick_n(11);  check("lost_update", pwm, 3'b001);

    // Over-range duty is clamped to SLOT_LEN-DEAD_TIME.
    duty_in = 6'd40; presc_in = 8'd0; upd_valid = 1'b1;
    tick_n(1);   check("clamp_taken", upd_ready, 0);
    upd_valid = 1'b0;
    tick_n(88);  check("clamp_rot", rot_pulse, 1);
    tick_n(2);   check("clamp_dead", pwm, 0);
    tick_n(1);   check("clamp_rise", pwm, 3'b001);
    tick_n(30);  check("clamp_last", pwm, 3'b001);
    tick_n(1);   check("clamp_next", pwm, 0);      check("clamp_idx", phase_idx, 1);

    // Zero duty: no pulses, phases still rotate.
    duty_in = 6'd0; upd_valid = 1'b1;
    tick_n(1);   check("zero_taken", upd_ready, 0);
    upd_valid = 1'b0;
    tick_n(64);  check("zero_rot", rot_pulse, 1);
    tick_n(51);  check("zero_p1_pwm", pwm, 0);     check("zero_p1_idx", phase_idx, 1);
    tick_n(40);  check("zero_p2_pwm", pwm, 0);     check("zero_p2_idx", phase_idx, 2);

    // Graceful stop from the middle of phase 1.
    duty_in = 6'd31; upd_valid = 1'b1;
    tick_n(1);
    upd_valid = 1'b0;
    tick_n(7);   check("restore_rot", rot_pulse, 1);
    tick_n(52);
    en = 1'b0;
    tick_n(13);  check("stop_pulse", pwm, 3'b010); check("stop_busy", busy, 1);
    tick_n(1);   check("stop_last", pwm, 3'b010); check("stop_idle", busy, 0);
    check("stop_norot", rot_pulse, 0);
    tick_n(1);   check("idle_pwm", pwm, 0);        check("idle_idx", phase_idx, 0);

    // en drops then returns during STOPPING: sequence carries on into phase 2.
    en = 1'b1;
    tick_n(40);
    en = 1'b0;
    tick_n(2);   check("stp_busy", busy, 1);       check("stp_pwm", pwm, 3'b010);
    en = 1'b1;
    tick_n(3);   check("resume_busy", busy, 1);
    tick_n(23);  check("resume_idx", phase_idx, 2);
    tick_n(2);   check("resume_pwm", pwm, 3'b100);

`ifdef PWM_DIR_EN
    // Reverse order 0,2,1,0; a dir change lands only at the next boundary.
    rst = 1'b1; en = 1'b0;
    tick_n(1);
    rst = 1'b0; dir = 1'b1; en = 1'b1;
    tick_n(35);  check("rev_idx2", phase_idx, 2);
    tick_n(33);  check("rev_idx1", phase_idx, 1);
    tick_n(32);  check("rev_rot", rot_pulse, 1);
    tick_n(1);   check("rev_idx0", phase_idx, 0);
    tick_n(9);
    dir = 1'b0;
    tick_n(24);  check("rev_hold", phase_idx, 2);
    tick_n(99);  check("fwd_after", phase_idx, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
